mole_round_scheduler: RTL

Game-round controller for Whac-A-Mole. Sequences mole appearances over a 3x3 hole grid using an LFSR and tick timers. Detects hits from PS/2 mouse left-click position and keeps score, miss and time counters. Its outputs drive the VGA pixel-composition logic and the 7-segment display.

---
 rtl/mole_round_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mole_round_scheduler.sv
// Whac-A-Mole round controller: mole sequencing on a 3x3 grid, hit detection
// from mouse clicks, and score/miss/time bookkeeping for display logic.
module mole_round_scheduler #(
    parameter int TICK_DIV   = 100000,
    parameter int GAP_TICKS  = 300,
    parameter int UP_TICKS   = 800,
    parameter int GAME_TICKS = 30000,
    parameter int HOLE_X0    = 120,
    parameter int HOLE_Y0    = 40,
    parameter int HOLE_PITCH = 140,
    parameter int HOLE_SIZE  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic        left_btn,
    output logic [8:0]  mole_active,
    output logic [15:0] score,
    output logic [7:0]  misses,
    output logic [15:0] time_left,
    output logic        hit_pulse,
    output logic        game_over
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   phase;
    logic [3:0]    lfsr;
    logic [3:0]    hole;
    logic [3:0]    base;
    logic [3:0]    pick;
    logic          btn_q;
    logic          click_q;
    logic [2:0]    col_hit;
    logic [2:0]    row_hit;
    logic [8:0]    hole_hit;
    logic          tick;
    logic          hit;
    logic          timeout;
    logic          gap_done;
    logic          round_end;

    always_comb begin
        col_hit  = '0;
        row_hit  = '0;
        hole_hit = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            col_hit[i] = ({1'b0, x_pos} >= 13'(HOLE_X0 + i * HOLE_PITCH)) &&
                         ({1'b0, x_pos} <  13'(HOLE_X0 + i * HOLE_PITCH + HOLE_SIZE));
            row_hit[i] = ({1'b0, y_pos} >= 13'(HOLE_Y0 + i * HOLE_PITCH)) &&
                         ({1'b0, y_pos} <  13'(HOLE_Y0 + i * HOLE_PITCH + HOLE_SIZE));
        end
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                hole_hit[r * 3 + c] = row_hit[r] & col_hit[c];
            end
        end
    end

    // Fold the 1..15 LFSR range onto 0..8 and step past the previous hole.
    always_comb begin
        base = (lfsr >= 4'd9) ? lfsr - 4'd9 : lfsr;
        pick = base;
        if (base == hole) begin
            pick = (base == 4'd8) ? 4'd0 : base + 4'd1;
        end
    end

    always_comb begin
        tick      = ((state == GAP) || (state == UP)) && (presc == PW'(TICK_DIV - 1));
        hit       = (state == UP) && click_q && (|(mole_active & hole_hit));
        timeout   = (state == UP) && tick && (phase == 16'(UP_TICKS - 1));
        gap_done  = (state == GAP) && tick && (phase == 16'(GAP_TICKS - 1));
        round_end = tick && (time_left == 16'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            phase       <= '0;
            lfsr        <= 4'b0001;
            hole        <= '0;
            btn_q       <= 1'b0;
            click_q     <= 1'b0;
            mole_active <= '0;
            score       <= '0;
            misses      <= '0;
            time_left   <= 16'(GAME_TICKS);
            hit_pulse   <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            lfsr      <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            btn_q     <= left_btn;
            click_q   <= left_btn & ~btn_q;
            hit_pulse <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    presc       <= '0;
                    phase       <= '0;
                    mole_active <= '0;
                    if (start) begin
                        state     <= GAP;
                        score     <= '0;
                        misses    <= '0;
                        time_left <= 16'(GAME_TICKS);
                        game_over <= 1'b0;
                    end
                end
                GAP, UP: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        time_left <= time_left - 16'd1;
                    end
                    if (hit) begin
                        if (score != 16'hFFFF) score <= score + 16'd1;
                        hit_pulse <= 1'b1;
                    end else if (timeout) begin
                        if (misses != 8'hFF) misses <= misses + 8'd1;
                    end
                    // End of round only overrides the state move; the hit or miss above still counts.
                    if (round_end) begin
                        state       <= OVER;
                        game_over   <= 1'b1;
                        mole_active <= '0;
                        presc       <= '0;
                        phase       <= '0;
                    end else if (hit || timeout) begin
                        state       <= GAP;
                        mole_active <= '0;
                        presc       <= '0;
                        phase       <= '0;
                    end else if (gap_done) begin
                        state       <= UP;
                        hole        <= pick;
                        mole_active <= 9'd1 << pick;
                        phase       <= '0;
                    end else if (tick) begin
                        phase <= phase + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
